// File: rtl/combat_scheduler.sv
// Two-side combat round scheduler: frame timebase, start/countdown/play/hit-stop/result
// sequencing, and per-side HP and post-hit invulnerability tracking.

module combat_side #(
    parameter int INVULN_FR = 60,
    parameter int HP_INIT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       play,
    input  logic       tick,
    input  logic       hit,
    input  logic       shield,
    output logic       accept,
    output logic [1:0] hp,
    output logic       invuln
);
    localparam int IW = (INVULN_FR > 0) ? $clog2(INVULN_FR + 1) : 1;

    logic [IW-1:0] inv_cnt;

    // A hit only lands on an unshielded, non-invulnerable side during live play.
    assign accept = play && hit && !shield && (inv_cnt == '0);
    assign invuln = (inv_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp      <= 2'(HP_INIT);
            inv_cnt <= '0;
        end else if (load) begin
            hp      <= 2'(HP_INIT);
            inv_cnt <= '0;
        end else if (accept) begin
            hp      <= (hp == 2'd0) ? 2'd0 : hp - 2'd1;
            inv_cnt <= IW'(INVULN_FR);
        end else if (play && tick && (inv_cnt != '0)) begin
            inv_cnt <= inv_cnt - IW'(1);
        end
    end
endmodule

module combat_scheduler #(
    parameter int FRAME_CYC  = 833333,
    parameter int SEC_FR     = 60,
    parameter int INVULN_FR  = 60,
    parameter int HITSTOP_FR = 8,
    parameter int HP_INIT    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_select,
    input  logic       i_player_hit,
    input  logic       i_enemy_hit,
    input  logic       i_player_shield,
    input  logic       i_enemy_shield,
    output logic [2:0] o_state,
    output logic       o_frame_tick,
    output logic       o_update_en,
    output logic [1:0] o_player_hp,
    output logic [1:0] o_enemy_hp,
    output logic       o_player_invuln,
    output logic       o_enemy_invuln,
    output logic [1:0] o_countdown
);
    localparam int FW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int SW = (SEC_FR > 1) ? $clog2(SEC_FR) : 1;
    localparam int HW = (HITSTOP_FR > 0) ? $clog2(HITSTOP_FR + 1) : 1;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_HITSTOP   = 3'd3,
        S_WIN       = 3'd4,
        S_LOSE      = 3'd5,
        S_DRAW      = 3'd6
    } state_t;

    state_t        state, state_d;
    logic [FW-1:0] frame_cnt;
    logic [SW-1:0] step, step_d;
    logic [HW-1:0] hs_cnt, hs_d;
    logic [1:0]    cd, cd_d;
    logic          tick, load, play;

    // Index 0 is the player, index 1 the enemy.
    logic [1:0]      hit_v, shield_v, accept_v, invuln_v;
    logic [1:0][1:0] hp_v;

    assign tick = (frame_cnt == FW'(FRAME_CYC - 1));
    assign play = (state == S_PLAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    frame_cnt <= '0;
        else if (tick) frame_cnt <= '0;
        else           frame_cnt <= frame_cnt + FW'(1);
    end

    assign hit_v    = {i_enemy_hit, i_player_hit};
    assign shield_v = {i_enemy_shield, i_player_shield};

    for (genvar g = 0; g < 2; g++) begin : g_side
        combat_side #(
            .INVULN_FR (INVULN_FR),
            .HP_INIT   (HP_INIT)
        ) u_side (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load),
            .play   (play),
            .tick   (tick),
            .hit    (hit_v[g]),
            .shield (shield_v[g]),
            .accept (accept_v[g]),
            .hp     (hp_v[g]),
            .invuln (invuln_v[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_START;
            step   <= '0;
            hs_cnt <= '0;
            cd     <= 2'd0;
        end else begin
            state  <= state_d;
            step   <= step_d;
            hs_cnt <= hs_d;
            cd     <= cd_d;
        end
    end

    always_comb begin
        state_d = state;
        step_d  = step;
        hs_d    = hs_cnt;
        cd_d    = cd;
        load    = 1'b0;
        case (state)
            S_START: begin
                if (i_select) begin
                    state_d = S_COUNTDOWN;
                    cd_d    = 2'd3;
                    step_d  = '0;
                    load    = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (step == SW'(SEC_FR - 1)) begin
                        step_d = '0;
                        if (cd == 2'd1) begin
                            state_d = S_PLAY;
                            cd_d    = 2'd0;
                        end else begin
                            cd_d = cd - 2'd1;
                        end
                    end else begin
                        step_d = step + SW'(1);
                    end
                end
            end
            S_PLAY: begin
                if (|accept_v) begin
                    state_d = S_HITSTOP;
                    hs_d    = HW'(HITSTOP_FR);
                end
            end
            S_HITSTOP: begin
                if (tick) begin
                    if (hs_cnt != '0) hs_d = hs_cnt - HW'(1);
                    // HP was already decremented on entry, so the outcome reads the live values.
                    if (hs_cnt == HW'(1)) begin
                        if (hp_v[0] == 2'd0 && hp_v[1] == 2'd0) state_d = S_DRAW;
                        else if (hp_v[0] == 2'd0)               state_d = S_LOSE;
                        else if (hp_v[1] == 2'd0)               state_d = S_WIN;
                        else                                     state_d = S_PLAY;
                    end
                end
            end
            S_WIN, S_LOSE, S_DRAW: begin
                if (i_select) state_d = S_START;
            end
            default: state_d = S_START;
        endcase
    end

    assign o_state         = state;
    assign o_frame_tick    = tick;
    assign o_update_en     = tick && play;
    assign o_player_hp     = hp_v[0];
    assign o_enemy_hp      = hp_v[1];
    assign o_player_invuln = invuln_v[0];
    assign o_enemy_invuln  = invuln_v[1];
    assign o_countdown     = cd;
endmodule

// File: tb/tb_combat_scheduler.sv
// Directed bench for combat_scheduler with a small frame so a full round fits in a few hundred cycles.

module tb_combat_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_select = 1'b0, i_player_hit = 1'b0, i_enemy_hit = 1'b0;
    logic       i_player_shield = 1'b0, i_enemy_shield = 1'b0;
    logic [2:0] o_state;
    logic       o_frame_tick, o_update_en;
    logic [1:0] o_player_hp, o_enemy_hp, o_countdown;
    logic       o_player_invuln, o_enemy_invuln;

    int checks = 0;
    int errors = 0;

    combat_scheduler #(
        .FRAME_CYC  (4),
        .SEC_FR     (2),
        .INVULN_FR  (3),
        .HITSTOP_FR (2),
        .HP_INIT    (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_select        (i_select),
        .i_player_hit    (i_player_hit),
        .i_enemy_hit     (i_enemy_hit),
        .i_player_shield (i_player_shield),
        .i_enemy_shield  (i_enemy_shield),
        .o_state         (o_state),
        .o_frame_tick    (o_frame_tick),
        .o_update_en     (o_update_en),
        .o_player_hp     (o_player_hp),
        .o_enemy_hp      (o_enemy_hp),
        .o_player_invuln (o_player_invuln),
        .o_enemy_invuln  (o_enemy_invuln),
        .o_countdown     (o_countdown)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel, ph, eh, ps, es;
        int         ticks;
        logic [2:0] st;
        logic [1:0] php, ehp;
        logic       pinv, einv;
        logic [1:0] cd;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic sel, ph, eh, ps, es, input int ticks,
                                input logic [2:0] st, input logic [1:0] php, ehp,
                                input logic pinv, einv, input logic [1:0] cd);
        vec_t v;
        v.sel = sel; v.ph = ph; v.eh = eh; v.ps = ps; v.es = es; v.ticks = ticks;
        v.st = st; v.php = php; v.ehp = ehp; v.pinv = pinv; v.einv = einv; v.cd = cd;
        return v;
    endfunction

    function automatic logic [10:0] obs();
        return {o_state, o_player_hp, o_enemy_hp, o_player_invuln, o_enemy_invuln, o_countdown};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consumes n frame-tick edges and leaves the bench on the negedge after the last one.
    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int cyc = 0;
            while (!o_frame_tick && cyc < 16) begin
                @(negedge clk);
                cyc++;
            end
            if (!o_frame_tick) begin
                checks++;
                errors++;
                $display("FAIL tick_timeout: got no tick expected tick within 16 cycles");
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // sel ph eh ps es ticks | state php ehp pinv einv cd
        vecs[0]  = mk(0,0,0,0,0, 0, 3'd0, 2'd3, 2'd3, 0, 0, 2'd0);
        vecs[1]  = mk(1,0,0,0,0, 0, 3'd1, 2'd3, 2'd3, 0, 0, 2'd3);
        vecs[2]  = mk(0,0,0,0,0, 1, 3'd1, 2'd3, 2'd3, 0, 0, 2'd3);
        vecs[3]  = mk(0,0,0,0,0, 1, 3'd1, 2'd3, 2'd3, 0, 0, 2'd2);
        vecs[4]  = mk(0,0,0,0,0, 2, 3'd1, 2'd3, 2'd3, 0, 0, 2'd1);
        vecs[5]  = mk(0,0,0,0,0, 2, 3'd2, 2'd3, 2'd3, 0, 0, 2'd0);
        vecs[6]  = mk(0,0,1,0,0, 0, 3'd3, 2'd3, 2'd2, 0, 1, 2'd0);
        vecs[7]  = mk(0,0,0,0,0, 1, 3'd3, 2'd3, 2'd2, 0, 1, 2'd0);
        vecs[8]  = mk(0,0,0,0,0, 1, 3'd2, 2'd3, 2'd2, 0, 1, 2'd0);
        vecs[9]  = mk(0,0,0,0,0, 2, 3'd2, 2'd3, 2'd2, 0, 1, 2'd0);
        vecs[10] = mk(0,0,0,0,0, 1, 3'd2, 2'd3, 2'd2, 0, 0, 2'd0);
        vecs[11] = mk(0,1,0,1,0, 0, 3'd2, 2'd3, 2'd2, 0, 0, 2'd0);
        vecs[12] = mk(1,0,0,0,0, 0, 3'd2, 2'd3, 2'd2, 0, 0, 2'd0);
        vecs[13] = mk(0,1,1,0,0, 0, 3'd3, 2'd2, 2'd1, 1, 1, 2'd0);
        vecs[14] = mk(0,0,0,0,0, 2, 3'd2, 2'd2, 2'd1, 1, 1, 2'd0);
        vecs[15] = mk(0,1,0,0,0, 0, 3'd2, 2'd2, 2'd1, 1, 1, 2'd0);
        vecs[16] = mk(0,0,0,0,0, 3, 3'd2, 2'd2, 2'd1, 0, 0, 2'd0);
        vecs[17] = mk(0,1,0,0,0, 0, 3'd3, 2'd1, 2'd1, 1, 0, 2'd0);
        vecs[18] = mk(0,0,0,0,0, 2, 3'd2, 2'd1, 2'd1, 1, 0, 2'd0);
        vecs[19] = mk(0,0,0,0,0, 3, 3'd2, 2'd1, 2'd1, 0, 0, 2'd0);
        vecs[20] = mk(0,1,1,0,0, 0, 3'd3, 2'd0, 2'd0, 1, 1, 2'd0);
        vecs[21] = mk(0,0,0,0,0, 1, 3'd3, 2'd0, 2'd0, 1, 1, 2'd0);
        vecs[22] = mk(0,0,0,0,0, 1, 3'd6, 2'd0, 2'd0, 1, 1, 2'd0);
        vecs[23] = mk(0,1,0,0,0, 0, 3'd6, 2'd0, 2'd0, 1, 1, 2'd0);
        vecs[24] = mk(1,0,0,0,0, 0, 3'd0, 2'd0, 2'd0, 1, 1, 2'd0);
        vecs[25] = mk(1,0,0,0,0, 0, 3'd1, 2'd3, 2'd3, 0, 0, 2'd3);

        repeat (3) @(negedge clk);
        chk("reset_outputs", 16'(obs()), 16'({3'd0, 2'd3, 2'd3, 1'b0, 1'b0, 2'd0}));
        chk("reset_tick", 16'({o_frame_tick, o_update_en}), 16'd0);

        // Idle after release: tick on cycles 3, 7, 11, never an update enable.
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("idle_tick_c%0d", c), 16'({o_frame_tick, o_update_en, o_state}),
                16'({(c % 4) == 3, 1'b0, 3'd0}));
            @(negedge clk);
        end

        for (int i = 0; i < 26; i++) begin
            if (vecs[i].sel || vecs[i].ph || vecs[i].eh || vecs[i].ps || vecs[i].es) begin
                i_select        = vecs[i].sel;
                i_player_hit    = vecs[i].ph;
                i_enemy_hit     = vecs[i].eh;
                i_player_shield = vecs[i].ps;
                i_enemy_shield  = vecs[i].es;
                @(negedge clk);
                i_select = 1'b0; i_player_hit = 1'b0; i_enemy_hit = 1'b0;
                i_player_shield = 1'b0; i_enemy_shield = 1'b0;
            end
            wait_ticks(vecs[i].ticks);
            chk($sformatf("vec%0d", i), 16'(obs()),
                16'({vecs[i].st, vecs[i].php, vecs[i].ehp, vecs[i].pinv, vecs[i].einv, vecs[i].cd}));
        end

        // Into PLAY again, confirm update enable, then reset in the middle of a hit-stop.
        wait_ticks(6);
        chk("replay_state", 16'(o_state), 16'd2);
        begin
            int cyc = 0;
            while (!o_frame_tick && cyc < 16) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("update_en_play", 16'({o_frame_tick, o_update_en}), 16'b11);
        i_enemy_hit = 1'b1;
        @(negedge clk);
        i_enemy_hit = 1'b0;
        chk("hitstop_before_reset", 16'(obs()), 16'({3'd3, 2'd3, 2'd2, 1'b0, 1'b1, 2'd0}));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 16'(obs()), 16'({3'd0, 2'd3, 2'd3, 1'b0, 1'b0, 2'd0}));
        chk("async_reset_tick", 16'({o_frame_tick, o_update_en}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("after_release", 16'(obs()), 16'({3'd0, 2'd3, 2'd3, 1'b0, 1'b0, 2'd0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
